// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keycode receiver: frame states,
// scan-code set 2 values, HID codes and the scan-code to HID translation.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_D    = 8'h07;
  localparam logic [7:0] KEY_NONE = 8'h00;

  function automatic logic [7:0] sc2hid(input logic [7:0] sc);
    logic [7:0] hid;
    case (sc)
      SC_W:    hid = KEY_W;
      SC_A:    hid = KEY_A;
      SC_S:    hid = KEY_S;
      SC_D:    hid = KEY_D;
      default: hid = KEY_NONE;
    endcase
    return hid;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchroniser on PS/2 clock and data, FILTER_LEN-sample debounce on
// the clock, and a one-cycle pulse on each accepted falling edge.
module ps2_clk_filter
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall_pulse,
  output logic dat_sync
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_meta;
  logic [1:0]    dat_meta;
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;
  logic          flip;

  // Bus idles high, so the synchronisers and filter come out of reset high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta <= 2'b11;
      dat_meta <= 2'b11;
    end else begin
      clk_meta <= {clk_meta[0], ps2_clk};
      dat_meta <= {dat_meta[0], ps2_dat};
    end
  end

  assign dat_sync = dat_meta[1];

  // Down-counter restarts whenever the synced level agrees with the filtered one.
  assign flip = (clk_meta[1] != clk_filt) && (flt_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt   <= 1'b1;
      flt_cnt    <= FW'(FILTER_LEN - 1);
      fall_pulse <= 1'b0;
    end else begin
      fall_pulse <= flip && clk_filt;
      if (clk_meta[1] == clk_filt || flip) begin
        flt_cnt <= FW'(FILTER_LEN - 1);
      end else begin
        flt_cnt <= flt_cnt - 1'b1;
      end
      if (flip) begin
        clk_filt <= ~clk_filt;
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host frame receiver and set-2 W/A/S/D to HID keycode decoder.
// Define PS2_PARITY_CHECK_EN to reject frames failing odd parity.
//
// state  | meaning
// IDLE   | waiting for a start bit (edge with data low)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | checking the stop bit, delivering the byte
module ps2_keycode_rx
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       key_strobe,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          fall_pulse;
  logic          dat_s;

  frame_state_t  state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          par_bad, par_bad_nxt;
  logic          byte_valid, byte_valid_nxt;
  logic          err_nxt;
  logic [TW-1:0] to_cnt;
  logic          timeout;

  logic          brk, ext;
  logic [7:0]    mapped;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .fall_pulse(fall_pulse),
    .dat_sync  (dat_s)
  );

  // Inter-edge watchdog, reloaded on every edge and held loaded while idle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      to_cnt <= TW'(TIMEOUT_CYC);
    end else if (fall_pulse || state == IDLE) begin
      to_cnt <= TW'(TIMEOUT_CYC);
    end else if (to_cnt != '0) begin
      to_cnt <= to_cnt - 1'b1;
    end
  end

  assign timeout = (state != IDLE) && (to_cnt == '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_bad    <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      par_bad    <= par_bad_nxt;
      byte_valid <= byte_valid_nxt;
      frame_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shreg_nxt      = shreg;
    par_bad_nxt    = par_bad;
    byte_valid_nxt = 1'b0;
    err_nxt        = 1'b0;
    if (timeout) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
    end else if (fall_pulse) begin
      case (state)
        IDLE: begin
          if (!dat_s) begin
            state_nxt   = DATA;
            bit_cnt_nxt = 3'd0;
            par_bad_nxt = 1'b0;
          end
        end
        DATA: begin
          shreg_nxt   = {dat_s, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt = PARITY;
          end
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_bad_nxt = ~(^{shreg, dat_s});
`else
          par_bad_nxt = 1'b0;
`endif
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (dat_s && !par_bad) begin
            byte_valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // shreg holds the delivered byte while the frame FSM sits in IDLE.
  assign mapped = sc2hid(shreg);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keycode    <= KEY_NONE;
      key_strobe <= 1'b0;
      brk        <= 1'b0;
      ext        <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (byte_valid) begin
        if (shreg == SC_BREAK) begin
          brk <= 1'b1;
        end else if (shreg == SC_EXT) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (!ext) begin
            if (!brk) begin
              if (mapped != KEY_NONE && mapped != keycode) begin
                keycode    <= mapped;
                key_strobe <= 1'b1;
              end
            end else if (mapped != KEY_NONE && mapped == keycode) begin
              keycode    <= KEY_NONE;
              key_strobe <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed and randomized PS/2 frames against a byte-level reference model.
module tb_ps2_keycode_rx;

  localparam int FILT = 8;
  localparam int TOUT = 400;
  localparam int HALF = 20;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] keycode;
  logic       key_strobe;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_strobe = 0;
  int n_err = 0;
  int n_both = 0;
  int last_strobe_cyc = 0;
  int last_fall_cyc = 0;

  logic [7:0] mkey = 8'h00;
  bit         mbrk = 1'b0;
  bit         mext = 1'b0;

  ps2_keycode_rx #(
    .FILTER_LEN (FILT),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .keycode   (keycode),
    .key_strobe(key_strobe),
    .frame_err (frame_err)
  );

  always #10 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (key_strobe) begin
      n_strobe++;
      last_strobe_cyc = cyc;
    end
    if (frame_err) n_err++;
    if (key_strobe && frame_err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hid_of(input logic [7:0] b);
    case (b)
      8'h1D:   return 8'h1A;
      8'h1C:   return 8'h04;
      8'h1B:   return 8'h16;
      8'h23:   return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b, output int stb);
    logic [7:0] m;
    stb = 0;
    if (b == 8'hF0) mbrk = 1'b1;
    else if (b == 8'hE0) mext = 1'b1;
    else begin
      m = hid_of(b);
      if (!mext) begin
        if (!mbrk) begin
          if (m != 8'h00 && m != mkey) begin mkey = m; stb = 1; end
        end else if (m != 8'h00 && m == mkey) begin
          mkey = 8'h00; stb = 1;
        end
      end
      mbrk = 1'b0;
      mext = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge Clk) PS2_DAT = b;
    repeat (HALF) @(negedge Clk);
    PS2_CLK = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) @(negedge Clk);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par);
    logic par;
    par = ~(^b) ^ flip_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    @(negedge Clk) PS2_DAT = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit flip_par);
    int s0, e0, stb, exp_err;
    s0 = n_strobe;
    e0 = n_err;
    send_frame(b, flip_par);
    repeat (30) @(negedge Clk);
    stb = 0;
    exp_err = 0;
`ifdef PS2_PARITY_CHECK_EN
    if (flip_par) exp_err = 1;
    else model_byte(b, stb);
`else
    model_byte(b, stb);
`endif
    check({tag, " keycode"}, keycode, mkey);
    check({tag, " strobes"}, n_strobe - s0, stb);
    check({tag, " errors"}, n_err - e0, exp_err);
  endtask

  initial begin
    int s0, e0, lat, r;
    logic [7:0] b;

    repeat (3) @(negedge Clk);
    check("reset keycode", keycode, 8'h00);
    check("reset strobe", key_strobe, 1'b0);
    check("reset err", frame_err, 1'b0);
    Reset_n = 1'b1;
    repeat (5) @(negedge Clk);

    // Single make code and its latency from the stop-bit edge.
    run_frame("t2 1C", 8'h1C, 1'b0);
    lat = last_strobe_cyc - last_fall_cyc;
    check("t2 latency in window", ((lat >= FILT + 3) && (lat <= FILT + 5)), 1'b1);

    // Reset in the middle of a frame.
    s0 = n_strobe;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge Clk) Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    check("t1 keycode in reset", keycode, 8'h00);
    check("t1 strobes in reset", n_strobe - s0, 0);
    Reset_n = 1'b1;
    mkey = 8'h00; mbrk = 1'b0; mext = 1'b0;
    repeat (5) @(negedge Clk);
    run_frame("t1 1C after reset", 8'h1C, 1'b0);

    // Release, press, typematic repeat, release.
    run_frame("t3 F0", 8'hF0, 1'b0);
    run_frame("t3 1C brk", 8'h1C, 1'b0);
    run_frame("t3 1C make", 8'h1C, 1'b0);
    run_frame("t3 1C repeat", 8'h1C, 1'b0);
    run_frame("t3 F0b", 8'hF0, 1'b0);
    run_frame("t3 1C brk2", 8'h1C, 1'b0);

    // Last press wins; break of an older key is ignored; extended is consumed.
    run_frame("t4 1D", 8'h1D, 1'b0);
    run_frame("t4 23", 8'h23, 1'b0);
    run_frame("t4 F0", 8'hF0, 1'b0);
    run_frame("t4 1D brk", 8'h1D, 1'b0);
    check("t4 held key", keycode, 8'h07);
    run_frame("t4 E0", 8'hE0, 1'b0);
    run_frame("t4 E0 1C", 8'h1C, 1'b0);
    run_frame("t4 F0c", 8'hF0, 1'b0);
    run_frame("t4 23 brk", 8'h23, 1'b0);

    // Flipped parity bit.
    run_frame("t5 bad parity 1C", 8'h1C, 1'b1);

    // Clock stalls high after five bits.
    s0 = n_strobe;
    e0 = n_err;
    b = 8'hA5;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[i]);
    repeat (TOUT + 200) @(negedge Clk);
    check("t6 timeout err", n_err - e0, 1);
    check("t6 timeout strobes", n_strobe - s0, 0);
    check("t6 timeout keycode", keycode, mkey);
    run_frame("t6 1B after timeout", 8'h1B, 1'b0);

    // Randomized byte stream.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 7:    b = 8'h1D;
        1, 8:    b = 8'h1C;
        2, 9:    b = 8'h1B;
        3:       b = 8'h23;
        4:       b = 8'hF0;
        5:       b = 8'hE0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      run_frame($sformatf("rnd%0d %02h", k, b), b, 1'b0);
    end

    check("strobe and err never together", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
